// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the push-button gesture classifier.
//   EVT_*            : 2-bit gesture event codes carried on event_code
//   gesture_state_t  : state encoding of button_gesture_fsm
//   max_int()        : elaboration-time helper used to size the shared counter
// -----------------------------------------------------------------------------
package button_pkg;

  localparam logic [1:0] EVT_SINGLE = 2'b00;
  localparam logic [1:0] EVT_DOUBLE = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_REPEAT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } gesture_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gesture_timer.sv
// -----------------------------------------------------------------------------
// gesture_timer
// Loadable up-counter shared by the timed states of button_gesture_fsm.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset (counter to 0)
//   clr    : load 0 on the next edge (wins over en)
//   en     : increment on the next edge
//   limit  : run-time terminal value
//   tc     : high while the count equals limit
// -----------------------------------------------------------------------------
module gesture_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The owning FSM always leaves a timed state on tc, so the count never wraps.
  assign tc = (cnt_q == limit);

endmodule

// File: rtl/button_gesture_fsm.sv
// -----------------------------------------------------------------------------
// button_gesture_fsm
// Classifies debounced button activity into SINGLE / DOUBLE / LONG / REPEAT
// gesture events, emitted as one-cycle registered strobes.
// Configuration macro: GESTURE_REPEAT_EN -- when defined, each mcen pulse in
// the LONG state (not coinciding with scen) produces a REPEAT event; when
// undefined the REPEAT path is compiled out.
// Ports:
//   clk         : system clock
//   reset       : synchronous, active-high reset
//   dpb         : debounced button level
//   scen        : one-cycle pulse per accepted press
//   mcen        : periodic pulses while the button is held
//   event_valid : one-cycle gesture strobe
//   event_code  : gesture type (button_pkg::EVT_*), holds when not valid
//   busy        : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module button_gesture_fsm
  import button_pkg::*;
#(
  parameter int LONG_CYC = 50_000_000,
  parameter int DC_WIN   = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dpb,
  input  logic       scen,
  input  logic       mcen,
  output logic       event_valid,
  output logic [1:0] event_code,
  output logic       busy
);

  localparam int CW = $clog2(max_int(LONG_CYC, DC_WIN));

  gesture_state_t state_q, state_d;
  logic           event_valid_q, event_valid_d;
  logic [1:0]     event_code_q, event_code_d;
  logic           busy_q, busy_d;

  logic           tmr_clr;
  logic           tmr_en;
  logic [CW-1:0]  tmr_limit;
  logic           tmr_tc;

  gesture_timer #(
    .W (CW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .tc    (tmr_tc)
  );

`ifdef GESTURE_REPEAT_EN
`else
  // mcen only feeds the REPEAT path; sink it when that path is compiled out.
  logic unused_mcen;
  assign unused_mcen = mcen;
`endif

  always_comb begin
    state_d       = state_q;
    event_valid_d = 1'b0;
    event_code_d  = event_code_q;
    tmr_en        = 1'b0;
    tmr_limit     = CW'(DC_WIN - 1);

    unique case (state_q)
      ST_IDLE: begin
        if (scen) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        tmr_en    = 1'b1;
        tmr_limit = CW'(LONG_CYC - 1);
        // Release is tested first so it wins over the long-press threshold.
        if (!dpb) begin
          state_d = ST_WAIT2;
        end else if (tmr_tc) begin
          state_d       = ST_LONG;
          event_valid_d = 1'b1;
          event_code_d  = EVT_LONG;
        end
      end
      ST_WAIT2: begin
        tmr_en = 1'b1;
        // A second press wins over window expiry.
        if (scen) begin
          state_d       = ST_PRESS2;
          event_valid_d = 1'b1;
          event_code_d  = EVT_DOUBLE;
        end else if (tmr_tc) begin
          state_d       = ST_IDLE;
          event_valid_d = 1'b1;
          event_code_d  = EVT_SINGLE;
        end
      end
      ST_PRESS2: begin
        if (!dpb) state_d = ST_IDLE;
      end
      ST_LONG: begin
`ifdef GESTURE_REPEAT_EN
        // The debouncer raises mcen together with scen on a fresh press;
        // those coincident pulses are not hold repeats.
        if (mcen && !scen) begin
          event_valid_d = 1'b1;
          event_code_d  = EVT_REPEAT;
        end
`endif
        if (!dpb) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Every state change restarts the shared counter from 0.
    tmr_clr = (state_d != state_q);
    busy_d  = (state_d != ST_IDLE);
  end

  // NOTE: reset is synchronous and clears only control state and outputs; a
  // gesture in flight is simply abandoned with no event emitted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      event_valid_q <= 1'b0;
      event_code_q  <= EVT_SINGLE;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      event_valid_q <= event_valid_d;
      event_code_q  <= event_code_d;
      busy_q        <= busy_d;
    end
  end

  assign event_valid = event_valid_q;
  assign event_code  = event_code_q;
  assign busy        = busy_q;

endmodule
